maze_scenario_seq: RTL and testbench

Synthesizable scenario sequencer for MazeRunner system simulation and FPGA self-test. It replaces hand-scripted line/command stimulus with a programmable table of up to NUM_STEPS steps. Each step holds line_theta, line_present, a duration, an optional slew ramp and an optional robot-heading check. It sits between CommMaster (travel-plan command launch) and MazePhysics (line_theta/line_present inputs, theta_robot observation).

---
 rtl/maze_scenario_seq_if.sv | 50 +++++
 rtl/maze_scenario_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_maze_scenario_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_scenario_seq_if.sv
// Bundles the scenario sequencer's programming, CommMaster and MazePhysics signals.
// The master side is the host/bench, the slave side is the sequencer.
interface maze_scenario_seq_if #(
    parameter int NUM_STEPS = 8,
    parameter int THETA_W   = 13,
    parameter int DUR_W     = 24
);
    localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    logic                      prg_we;
    logic [AW-1:0]             prg_addr;
    logic signed [THETA_W-1:0] prg_theta;
    logic [DUR_W-1:0]          prg_dur;
    logic                      prg_line;
    logic                      prg_ramp;
    logic                      prg_check;
    logic                      prg_last;
    logic                      start;
    logic                      abort;
    logic [15:0]               plan;
    logic                      cmd_cmplt;
    logic signed [THETA_W-1:0] theta_robot;
    logic                      snd_cmd;
    logic [15:0]               cmd;
    logic signed [THETA_W-1:0] line_theta;
    logic                      line_present;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [1:0]                err_code;
    logic [AW-1:0]             err_step;
    logic [AW-1:0]             step_idx;
    logic [2:0]                dbg_state;

    // Command handshake: snd_cmd is a single-cycle request carrying cmd; the
    // request is complete on the first cycle cmd_cmplt is seen while waiting.
    modport master (
        output prg_we, prg_addr, prg_theta, prg_dur, prg_line, prg_ramp, prg_check,
               prg_last, start, abort, plan, cmd_cmplt, theta_robot,
        input  snd_cmd, cmd, line_theta, line_present, busy, done, err, err_code,
               err_step, step_idx, dbg_state
    );

    modport slave (
        input  prg_we, prg_addr, prg_theta, prg_dur, prg_line, prg_ramp, prg_check,
               prg_last, start, abort, plan, cmd_cmplt, theta_robot,
        output snd_cmd, cmd, line_theta, line_present, busy, done, err, err_code,
               err_step, step_idx, dbg_state
    );
endinterface

// File: rtl/maze_scenario_seq.sv
// Programmable scenario sequencer: launches a travel plan, then plays a table of
// line_theta/line_present steps with optional slew ramps and heading checks.
module maze_scenario_seq #(
    parameter int NUM_STEPS   = 8,
    parameter int THETA_W     = 13,
    parameter int DUR_W       = 24,
    parameter int TOL         = 10,
    parameter int SLEW_DIV    = 1024,
    parameter int CMPLT_TO    = 2000000,
    parameter int STOP_ON_ERR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    maze_scenario_seq_if.slave bus
);
    localparam int AW   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int TO_W = $clog2(CMPLT_TO + 1);
    localparam int SL_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam logic signed [THETA_W:0] TOL_P = (THETA_W + 1)'(TOL);
    localparam logic signed [THETA_W:0] TOL_N = -TOL_P;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT, S_RUN, S_CHECK, S_DONE
    } state_t;

    typedef struct packed {
        logic [THETA_W-1:0] theta;
        logic [DUR_W-1:0]   dur;
        logic               line;
        logic               ramp;
        logic               check;
        logic               last;
    } step_t;

    step_t tbl_q [NUM_STEPS];

    state_t                    state_q, state_d;
    logic [AW-1:0]             step_idx_q, step_idx_d;
    logic [DUR_W-1:0]          dur_cnt_q, dur_cnt_d;
    logic [SL_W-1:0]           slew_cnt_q, slew_cnt_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic signed [THETA_W-1:0] line_theta_q, line_theta_d;
    logic                      line_present_q, line_present_d;
    logic                      snd_cmd_q, snd_cmd_d;
    logic [15:0]               cmd_q, cmd_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [1:0]                err_code_q, err_code_d;
    logic [AW-1:0]             err_step_q, err_step_d;

    logic                      tbl_we, ld, adv, fin, chk_ok;
    logic [AW-1:0]             ld_idx;
    logic signed [THETA_W-1:0] cur_target;
    logic signed [THETA_W:0]   diff;

    always_comb begin
        state_d        = state_q;
        step_idx_d     = step_idx_q;
        dur_cnt_d      = dur_cnt_q;
        slew_cnt_d     = slew_cnt_q;
        to_cnt_d       = to_cnt_q;
        line_theta_d   = line_theta_q;
        line_present_d = line_present_q;
        snd_cmd_d      = 1'b0;
        cmd_d          = cmd_q;
        busy_d         = busy_q;
        done_d         = done_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        err_step_d     = err_step_q;
        tbl_we         = 1'b0;
        ld             = 1'b0;
        adv            = 1'b0;
        fin            = 1'b0;
        ld_idx         = '0;
        cur_target     = $signed(tbl_q[step_idx_q].theta);
        // One extra bit keeps extreme target/heading pairs from wrapping into a pass.
        diff   = $signed({bus.theta_robot[THETA_W-1], bus.theta_robot})
               - $signed({cur_target[THETA_W-1], cur_target});
        chk_ok = (diff >= TOL_N) && (diff <= TOL_P);

        case (state_q)
            S_IDLE, S_DONE: begin
                tbl_we = bus.prg_we;
                if (bus.start && !bus.abort) begin
                    state_d    = S_SEND;
                    snd_cmd_d  = 1'b1;
                    cmd_d      = bus.plan;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    err_step_d = '0;
                    step_idx_d = '0;
                    to_cnt_d   = '0;
                end
            end
            S_SEND: begin
                // The timeout counts from the snd_cmd cycle itself.
                state_d  = S_WAIT;
                to_cnt_d = to_cnt_q + 1'b1;
            end
            S_WAIT: begin
                if (bus.cmd_cmplt) begin
                    ld = 1'b1;
                end else if (to_cnt_q >= TO_W'(CMPLT_TO - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    fin        = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (tbl_q[step_idx_q].ramp && (line_theta_q != cur_target)) begin
                    if (slew_cnt_q == SL_W'(SLEW_DIV - 1)) begin
                        slew_cnt_d   = '0;
                        line_theta_d = (cur_target > line_theta_q) ? line_theta_q + THETA_W'(1)
                                                                   : line_theta_q - THETA_W'(1);
                    end else begin
                        slew_cnt_d = slew_cnt_q + 1'b1;
                    end
                end
                if (dur_cnt_q <= DUR_W'(1)) begin
                    if (tbl_q[step_idx_q].check) state_d = S_CHECK;
                    else                         adv     = 1'b1;
                end else begin
                    dur_cnt_d = dur_cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (!chk_ok) begin
                    if (!err_q) begin
                        err_code_d = 2'd1;
                        err_step_d = step_idx_q;
                    end
                    err_d = 1'b1;
                    if (STOP_ON_ERR != 0) fin = 1'b1;
                    else                  adv = 1'b1;
                end else begin
                    adv = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (tbl_q[step_idx_q].last || (step_idx_q == AW'(NUM_STEPS - 1))) begin
                fin = 1'b1;
            end else begin
                ld         = 1'b1;
                ld_idx     = step_idx_q + 1'b1;
                step_idx_d = ld_idx;
            end
        end

        if (ld) begin
            state_d        = S_RUN;
            line_present_d = tbl_q[ld_idx].line;
            dur_cnt_d      = (tbl_q[ld_idx].dur == '0) ? DUR_W'(1) : tbl_q[ld_idx].dur;
            slew_cnt_d     = '0;
            if (!tbl_q[ld_idx].ramp) line_theta_d = $signed(tbl_q[ld_idx].theta);
        end

        if (fin) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Abort leaves the error record exactly as it was before this cycle.
        if (bus.abort && busy_q) begin
            state_d        = S_IDLE;
            line_present_d = 1'b1;
            busy_d         = 1'b0;
            done_d         = 1'b0;
            step_idx_d     = step_idx_q;
            err_d          = err_q;
            err_code_d     = err_code_q;
            err_step_d     = err_step_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            step_idx_q     <= '0;
            dur_cnt_q      <= '0;
            slew_cnt_q     <= '0;
            to_cnt_q       <= '0;
            line_theta_q   <= '0;
            line_present_q <= 1'b1;
            snd_cmd_q      <= 1'b0;
            cmd_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= 2'd0;
            err_step_q     <= '0;
        end else begin
            state_q        <= state_d;
            step_idx_q     <= step_idx_d;
            dur_cnt_q      <= dur_cnt_d;
            slew_cnt_q     <= slew_cnt_d;
            to_cnt_q       <= to_cnt_d;
            line_theta_q   <= line_theta_d;
            line_present_q <= line_present_d;
            snd_cmd_q      <= snd_cmd_d;
            cmd_q          <= cmd_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            err_step_q     <= err_step_d;
        end
        if (tbl_we) begin
            tbl_q[bus.prg_addr] <= {bus.prg_theta, bus.prg_dur, bus.prg_line,
                                    bus.prg_ramp, bus.prg_check, bus.prg_last};
        end
    end

    assign bus.snd_cmd      = snd_cmd_q;
    assign bus.cmd          = cmd_q;
    assign bus.line_theta   = line_theta_q;
    assign bus.line_present = line_present_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
    assign bus.err_step     = err_step_q;
    assign bus.step_idx     = step_idx_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_maze_scenario_seq.sv
// Directed bench for maze_scenario_seq: two instances differing only in STOP_ON_ERR
// share every input; expected values are hand-computed cycle counts and angles.
module tb_maze_scenario_seq;
    localparam int SLEW = 4;
    localparam int TO   = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   snd_cnt = 0;
    int   snd_before;

    always #5 clk = ~clk;

    maze_scenario_seq_if #(.NUM_STEPS(8), .THETA_W(13), .DUR_W(24)) b0 ();
    maze_scenario_seq_if #(.NUM_STEPS(8), .THETA_W(13), .DUR_W(24)) b1 ();

    maze_scenario_seq #(.NUM_STEPS(8), .THETA_W(13), .DUR_W(24), .TOL(10), .SLEW_DIV(SLEW),
                        .CMPLT_TO(TO), .STOP_ON_ERR(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    maze_scenario_seq #(.NUM_STEPS(8), .THETA_W(13), .DUR_W(24), .TOL(10), .SLEW_DIV(SLEW),
                        .CMPLT_TO(TO), .STOP_ON_ERR(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    assign b1.prg_we      = b0.prg_we;
    assign b1.prg_addr    = b0.prg_addr;
    assign b1.prg_theta   = b0.prg_theta;
    assign b1.prg_dur     = b0.prg_dur;
    assign b1.prg_line    = b0.prg_line;
    assign b1.prg_ramp    = b0.prg_ramp;
    assign b1.prg_check   = b0.prg_check;
    assign b1.prg_last    = b0.prg_last;
    assign b1.start       = b0.start;
    assign b1.abort       = b0.abort;
    assign b1.plan        = b0.plan;
    assign b1.cmd_cmplt   = b0.cmd_cmplt;
    assign b1.theta_robot = b0.theta_robot;

    always @(negedge clk) if (b0.snd_cmd === 1'b1) snd_cnt++;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int th, input int d, input bit ln, input bit rp,
                      input bit ck, input bit ls);
        b0.prg_we    = 1'b1;
        b0.prg_addr  = 3'(a);
        b0.prg_theta = 13'(th);
        b0.prg_dur   = 24'(d);
        b0.prg_line  = ln;
        b0.prg_ramp  = rp;
        b0.prg_check = ck;
        b0.prg_last  = ls;
        tick(1);
        b0.prg_we = 1'b0;
    endtask

    // Leaves the bench just after the edge that loads step 0.
    task automatic run_begin();
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        tick(1);
        b0.cmd_cmplt = 1'b1;
        tick(1);
        b0.cmd_cmplt = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_snd"}, b0.snd_cmd, 0);
        check({tag, "_cmd"}, b0.cmd, 0);
        check({tag, "_theta"}, b0.line_theta, 0);
        check({tag, "_line"}, b0.line_present, 1);
        check({tag, "_busy"}, b0.busy, 0);
        check({tag, "_done"}, b0.done, 0);
        check({tag, "_err"}, b0.err, 0);
        check({tag, "_code"}, b0.err_code, 0);
        check({tag, "_estep"}, b0.err_step, 0);
        check({tag, "_idx"}, b0.step_idx, 0);
        check({tag, "_busy1"}, b1.busy, 0);
    endtask

    initial begin
        b0.prg_we = 0; b0.prg_addr = 0; b0.prg_theta = 0; b0.prg_dur = 0;
        b0.prg_line = 0; b0.prg_ramp = 0; b0.prg_check = 0; b0.prg_last = 0;
        b0.start = 0; b0.abort = 0; b0.plan = 16'hA5C3; b0.cmd_cmplt = 0; b0.theta_robot = 0;

        // Reset
        tick(3);
        check_reset("rst");
        rst_n = 1'b1;
        tick(1);

        // Three-step scenario with exact step boundaries
        wr(0, 0, 100, 1, 0, 0, 0);
        wr(1, 150, 200, 0, 0, 0, 0);
        wr(2, 250, 100, 1, 0, 0, 1);
        snd_before = snd_cnt;
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        check("s1_snd", b0.snd_cmd, 1);
        check("s1_busy", b0.busy, 1);
        check("s1_cmd", b0.cmd, 16'hA5C3);
        tick(1);
        check("s1_snd_off", b0.snd_cmd, 0);
        tick(48);
        b0.cmd_cmplt = 1'b1;
        tick(1);
        b0.cmd_cmplt = 1'b0;
        check("s1_st0_idx", b0.step_idx, 0);
        check("s1_st0_line", b0.line_present, 1);
        tick(99);
        check("s1_st0_end", b0.step_idx, 0);
        tick(1);
        check("s1_st1_idx", b0.step_idx, 1);
        check("s1_st1_theta", b0.line_theta, 150);
        check("s1_st1_line", b0.line_present, 0);
        // Table write during a run must be ignored
        b0.prg_we = 1'b1; b0.prg_addr = 3'd2; b0.prg_theta = 13'd999;
        tick(1);
        b0.prg_we = 1'b0;
        tick(198);
        check("s1_st1_end", b0.step_idx, 1);
        tick(1);
        check("s1_st2_idx", b0.step_idx, 2);
        check("s1_st2_theta", b0.line_theta, 250);
        check("s1_st2_line", b0.line_present, 1);
        tick(99);
        check("s1_notdone", b0.done, 0);
        tick(1);
        check("s1_done", b0.done, 1);
        check("s1_busy_off", b0.busy, 0);
        check("s1_hold", b0.line_theta, 250);
        check("s1_snd_once", snd_cnt - snd_before, 1);

        // Ramp 0 -> 20
        wr(0, 0, 1, 1, 0, 0, 0);
        wr(1, 20, 100, 1, 1, 0, 1);
        run_begin();
        check("up_start", b0.line_theta, 0);
        tick(1);
        check("up_idx", b0.step_idx, 1);
        check("up_hold0", b0.line_theta, 0);
        for (int i = 1; i < 100; i++) begin
            tick(1);
            check("ramp_up", b0.line_theta, (i / SLEW > 20) ? 20 : i / SLEW);
        end
        tick(1);
        check("up_done", b0.done, 1);
        check("up_final", b0.line_theta, 20);

        // Ramp 0 -> -20
        wr(1, -20, 100, 1, 1, 0, 1);
        run_begin();
        check("dn_start", b0.line_theta, 0);
        tick(1);
        for (int i = 1; i < 100; i++) begin
            tick(1);
            check("ramp_dn", b0.line_theta, -((i / SLEW > 20) ? 20 : i / SLEW));
        end
        tick(1);
        check("dn_final", b0.line_theta, -20);

        // Heading checks: +10 passes, -11 fails at step 1
        wr(0, 400, 10, 1, 0, 1, 0);
        wr(1, 400, 10, 1, 0, 1, 0);
        wr(2, 0, 5, 1, 0, 0, 1);
        b0.theta_robot = 13'sd410;
        run_begin();
        tick(11);
        check("ck_pass_err", b0.err, 0);
        check("ck_pass_idx", b0.step_idx, 1);
        b0.theta_robot = 13'sd389;
        tick(11);
        check("ck_fail_err", b0.err, 1);
        check("ck_fail_code", b0.err_code, 1);
        check("ck_fail_step", b0.err_step, 1);
        check("ck_fail_adv", b0.step_idx, 2);
        check("ck_fail_busy", b0.busy, 1);
        check("stop_err", b1.err, 1);
        check("stop_code", b1.err_code, 1);
        check("stop_step", b1.err_step, 1);
        check("stop_done", b1.done, 1);
        check("stop_idx", b1.step_idx, 1);
        tick(5);
        check("ck_done", b0.done, 1);
        check("ck_err_keep", b0.err_step, 1);

        // Command completion timeout
        b0.start = 1'b1;
        tick(1);
        b0.start = 1'b0;
        check("to_snd", b0.snd_cmd, 1);
        check("to_clr", b0.err, 0);
        tick(TO - 1);
        check("to_early", b0.err, 0);
        tick(1);
        check("to_err", b0.err, 1);
        check("to_code", b0.err_code, 2);
        check("to_done", b0.done, 1);
        check("to_busy", b0.busy, 0);

        // Abort mid-ramp, then abort together with start
        wr(0, 0, 1, 1, 0, 0, 0);
        wr(1, 20, 100, 0, 1, 0, 1);
        run_begin();
        tick(10);
        check("ab_theta", b0.line_theta, 2);
        check("ab_line0", b0.line_present, 0);
        b0.abort = 1'b1;
        tick(1);
        b0.abort = 1'b0;
        check("ab_busy", b0.busy, 0);
        check("ab_done", b0.done, 0);
        check("ab_line", b0.line_present, 1);
        snd_before = snd_cnt;
        b0.start = 1'b1;
        b0.abort = 1'b1;
        tick(1);
        b0.start = 1'b0;
        b0.abort = 1'b0;
        check("abst_busy", b0.busy, 0);
        check("abst_snd", b0.snd_cmd, 0);
        tick(2);
        check("abst_nosnd", snd_cnt - snd_before, 0);

        // Synchronous reset mid-run
        run_begin();
        tick(20);
        rst_n = 1'b0;
        tick(1);
        check_reset("mid_rst");
        rst_n = 1'b1;
        tick(1);

        // Signed extreme must not wrap into a pass
        wr(0, -4096, 2, 1, 0, 1, 1);
        b0.theta_robot = 13'sd4095;
        run_begin();
        check("ext_theta", b0.line_theta, -4096);
        tick(3);
        check("ext_err", b0.err, 1);
        check("ext_code", b0.err_code, 1);
        check("ext_step", b0.err_step, 0);
        check("ext_done", b0.done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
